seq_gen: RTL and testbench

Serial pattern transmitter that drives the single-bit input of the sequence detector (any_seq). It shifts a WIDTH-bit pattern out MSB-first, one bit per clock, and repeats it a programmable number of times with an optional idle gap between repetitions. It is the stimulus source for detector bring-up and for loopback self-test. With gap 0 it produces back-to-back patterns, so overlapping detection can be exercised.

---
 rtl/seq_gen.sv | 177 +++++++++++++++++
 tb/tb_seq_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen
// Purpose  : Serial MSB-first pattern transmitter with repeat count and gap.
//            Optional macro SEQ_GEN_PARITY_EN appends an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module seq_gen #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] SEQ   = 5'b10010,
    parameter int               RPT_W = 8,
    parameter int               GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_pat,
    input  logic [RPT_W-1:0] rpt_cnt,
    input  logic [GAP_W-1:0] gap_cyc,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int             c_BIT_W = $clog2(WIDTH);
    localparam [c_BIT_W-1:0]   c_MSB   = c_BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_pat, w_pat_nxt;
    logic [c_BIT_W-1:0] r_bit, w_bit_nxt;
    logic [RPT_W-1:0]   r_rpt, w_rpt_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [GAP_W-1:0]   r_gap_len, w_gap_len_nxt;
    logic               r_par, w_par_nxt;
    logic               r_out, w_out_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               w_end_rep;
    logic [WIDTH-1:0]   w_pat_eff;
    logic [RPT_W-1:0]   w_rpt_eff;

    // A same-cycle load must be the pattern this transmission starts with.
    assign w_pat_eff = load_en ? load_pat : r_pat;
    assign w_rpt_eff = (rpt_cnt == '0) ? RPT_W'(1) : rpt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pat     <= SEQ;
            r_bit     <= '0;
            r_rpt     <= '0;
            r_gap     <= '0;
            r_gap_len <= '0;
            r_par     <= 1'b0;
            r_out     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pat     <= w_pat_nxt;
            r_bit     <= w_bit_nxt;
            r_rpt     <= w_rpt_nxt;
            r_gap     <= w_gap_nxt;
            r_gap_len <= w_gap_len_nxt;
            r_par     <= w_par_nxt;
            r_out     <= w_out_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // State encodes what is on the outputs now; the next bit is computed here
    // and registered so every output comes straight from a flop.
    always_comb begin
        w_state_nxt   = r_state;
        w_pat_nxt     = r_pat;
        w_bit_nxt     = r_bit;
        w_rpt_nxt     = r_rpt;
        w_gap_nxt     = r_gap;
        w_gap_len_nxt = r_gap_len;
        w_par_nxt     = r_par;
        w_out_nxt     = 1'b0;
        w_valid_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        w_end_rep     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (load_en) begin
                    w_pat_nxt = load_pat;
                end
                if (start) begin
                    w_state_nxt   = S_SEND;
                    w_bit_nxt     = c_MSB;
                    w_rpt_nxt     = w_rpt_eff;
                    w_gap_len_nxt = gap_cyc;
                    w_par_nxt     = 1'b0;
                    w_out_nxt     = w_pat_eff[c_MSB];
                    w_valid_nxt   = 1'b1;
                end
            end
            S_SEND: begin
                if (r_bit != '0) begin
                    w_bit_nxt   = r_bit - 1'b1;
                    w_out_nxt   = r_pat[r_bit - 1'b1];
                    w_valid_nxt = 1'b1;
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    if (!r_par) begin
                        w_par_nxt   = 1'b1;
                        w_out_nxt   = ^r_pat;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_par_nxt = 1'b0;
                        w_end_rep = 1'b1;
                    end
`else
                    w_end_rep = 1'b1;
`endif
                end
                if (w_end_rep) begin
                    if (r_rpt > RPT_W'(1)) begin
                        w_rpt_nxt = r_rpt - 1'b1;
                        if (r_gap_len != '0) begin
                            w_state_nxt = S_GAP;
                            w_gap_nxt   = r_gap_len;
                        end else begin
                            w_bit_nxt   = c_MSB;
                            w_out_nxt   = r_pat[c_MSB];
                            w_valid_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == GAP_W'(1)) begin
                    w_state_nxt = S_SEND;
                    w_bit_nxt   = c_MSB;
                    w_out_nxt   = r_pat[c_MSB];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_gen
// Purpose  : Directed self-checking bench for seq_gen (WIDTH=5, SEQ=10010).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_gen;

`ifdef SEQ_GEN_PARITY_EN
    localparam int c_PL = 6;
`else
    localparam int c_PL = 5;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       load_en  = 1'b0;
    logic [4:0] load_pat = '0;
    logic [7:0] rpt_cnt  = '0;
    logic [3:0] gap_cyc  = '0;
    logic       out, valid, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_gen #(
        .WIDTH (5),
        .SEQ   (5'b10010),
        .RPT_W (8),
        .GAP_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .load_en  (load_en),
        .load_pat (load_pat),
        .rpt_cnt  (rpt_cnt),
        .gap_cyc  (gap_cyc),
        .out      (out),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected concatenation of valid bits for r repetitions of pattern p.
    function automatic logic [63:0] rep_stream(input logic [4:0] p, input int r);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < r; i++) begin
            s = (s << 5) | 64'(p);
`ifdef SEQ_GEN_PARITY_EN
            s = (s << 1) | 64'(^p);
`endif
        end
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Inputs are set by the caller; this applies one start edge and monitors
    // the transmission until busy falls. At cycle inj, junk inputs are pulsed.
    task automatic run(input int inj, output logic [63:0] st, output int nv,
                       output int nb, output int dc, output int nd,
                       output int gap_hi, output int fv);
        bit fin;
        st = '0; nv = 0; nb = 0; dc = 0; nd = 0; gap_hi = 0; fv = 0; fin = 0;
        tick;
        start   = 1'b0;
        load_en = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (!busy) begin
                fin = 1;
                break;
            end
            nb++;
            if (valid) begin
                if (fv == 0) fv = c;
                st = {st[62:0], out};
                nv++;
            end else if (out) begin
                gap_hi++;
            end
            if (done) begin
                nd++;
                dc = c;
            end
            if (c == inj) begin
                start = 1'b1; load_en = 1'b1; load_pat = 5'b00000;
                rpt_cnt = 8'd9; gap_cyc = 4'd3;
            end else if (c == inj + 1) begin
                start = 1'b0; load_en = 1'b0;
            end
            tick;
        end
        if (!fin) check("timeout", 64'(busy), 64'd0);
    endtask

    logic [63:0] st;
    int nv, nb, dc, nd, gh, fv, cnt;

    initial begin
        #12;
        check("rst_out",   64'(out),   64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        rst_n = 1'b1;
        tick;

        // Single pattern, rpt=1, gap=0
        start = 1'b1; rpt_cnt = 8'd1; gap_cyc = 4'd0;
        run(0, st, nv, nb, dc, nd, gh, fv);
        check("t1_stream", st, rep_stream(5'b10010, 1));
        check("t1_nvalid", 64'(nv), 64'(c_PL));
        check("t1_busy",   64'(nb), 64'(c_PL + 1));
        check("t1_donecyc", 64'(dc), 64'(c_PL + 1));
        check("t1_ndone",  64'(nd), 64'd1);
        check("t1_first",  64'(fv), 64'd1);

        // Back-to-back, rpt=2, gap=0
        tick;
        start = 1'b1; rpt_cnt = 8'd2; gap_cyc = 4'd0;
        run(0, st, nv, nb, dc, nd, gh, fv);
        check("t2_stream", st, rep_stream(5'b10010, 2));
        check("t2_busy",   64'(nb), 64'(2 * c_PL + 1));
        check("t2_nvalid", 64'(nv), 64'(2 * c_PL));

        // rpt=3, gap=2; inputs changed while busy are ignored
        tick;
        start = 1'b1; rpt_cnt = 8'd3; gap_cyc = 4'd2;
        run(3, st, nv, nb, dc, nd, gh, fv);
        check("t3_stream", st, rep_stream(5'b10010, 3));
        check("t3_busy",   64'(nb), 64'(3 * c_PL + 2 * 2 + 1));
        check("t3_idle",   64'(nb - nv - nd), 64'd4);
        check("t3_gap_lo", 64'(gh), 64'd0);
        check("t3_donecyc", 64'(dc), 64'(3 * c_PL + 5));

        // rpt=0 acts as a single repetition
        tick;
        start = 1'b1; rpt_cnt = 8'd0; gap_cyc = 4'd5;
        run(0, st, nv, nb, dc, nd, gh, fv);
        check("t4_rpt0_busy", 64'(nb), 64'(c_PL + 1));
        check("t4_rpt0_stream", st, rep_stream(5'b10010, 1));

        // Load and start together: new pattern is sent
        tick;
        start = 1'b1; load_en = 1'b1; load_pat = 5'b11001; rpt_cnt = 8'd1; gap_cyc = 4'd0;
        run(0, st, nv, nb, dc, nd, gh, fv);
        check("t5_load_stream", st, rep_stream(5'b11001, 1));

        // Start alone: loaded pattern retained
        tick;
        start = 1'b1; rpt_cnt = 8'd1; gap_cyc = 4'd0;
        run(0, st, nv, nb, dc, nd, gh, fv);
        check("t6_keep_stream", st, rep_stream(5'b11001, 1));

        // start/load pulse while sending bit 3 is ignored
        tick;
        start = 1'b1; rpt_cnt = 8'd1; gap_cyc = 4'd0;
        run(2, st, nv, nb, dc, nd, gh, fv);
        check("t7_ign_stream", st, rep_stream(5'b11001, 1));
        check("t7_ign_busy",   64'(nb), 64'(c_PL + 1));

        // start held high: one IDLE cycle between transmissions
        tick;
        start = 1'b1; rpt_cnt = 8'd1; gap_cyc = 4'd0;
        tick;
        cnt = 0;
        for (int c = 1; c <= 2 * c_PL + 3; c++) begin
            if (busy) cnt++;
            tick;
        end
        check("t8_hold_busy", 64'(cnt), 64'(2 * c_PL + 2));
        start = 1'b0;
        for (int c = 0; c < 50 && busy; c++) tick;
        check("t8_idle", 64'(busy), 64'd0);

        // Asynchronous reset during bit 3 of 11001
        tick;
        start = 1'b1; rpt_cnt = 8'd1;
        tick;
        start = 1'b0;
        tick;
        check("t9_pre_out", 64'(out), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t9_rst_out",  64'(out),  64'd0);
        check("t9_rst_busy", 64'(busy), 64'd0);
        check("t9_rst_valid", 64'(valid), 64'd0);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick;
            if (done) cnt++;
        end
        rst_n = 1'b1;
        tick;
        if (done) cnt++;
        check("t9_no_done", 64'(cnt), 64'd0);

        // Pattern register returned to SEQ
        start = 1'b1; rpt_cnt = 8'd1; gap_cyc = 4'd0;
        run(0, st, nv, nb, dc, nd, gh, fv);
        check("t10_seq_stream", st, rep_stream(5'b10010, 1));

`ifdef SEQ_GEN_PARITY_EN
        tick;
        start = 1'b1; load_en = 1'b1; load_pat = 5'b10110; rpt_cnt = 8'd1;
        run(0, st, nv, nb, dc, nd, gh, fv);
        check("t11_par_stream", st, 64'b101101);
        check("t11_par_done",   64'(dc), 64'd7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
